async_fifo: RTL and testbench

ASYNC_FIFO -- requirements
Module: async_fifo

---
 rtl/async_fifo.sv | 115 +++++++++++
 tb/tb_async_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/async_fifo.sv
// Purpose : single-clock FIFO, SIZE x WIDTH, wrap-bit pointers with full/empty/count from registered pointers.
// Latency : a written word is readable the cycle after its write; data_out is registered and valid one edge after an accepted r_en.
// Backpr. : writes while full and reads while empty are dropped; at full both requests accept only the read, at empty only the write.
//
// Ports:
//   wclk      - sole clock, rising edge
//   arst_n    - asynchronous active-low reset (pointers, data_out, error flags; memory is not reset)
//   w_en      - write request          data_in  - write data (WIDTH)
//   r_en      - read request           data_out - registered read data (WIDTH)
//   full      - FIFO holds SIZE words  empty    - FIFO holds 0 words
//   count     - stored words, 0..SIZE (PTR_LEN+1 bits)
//   overflow  - sticky dropped-write flag   (only with ASYNC_FIFO_ERR_FLAGS_EN)
//   underflow - sticky dropped-read flag    (only with ASYNC_FIFO_ERR_FLAGS_EN)
//
// Optional feature macro: ASYNC_FIFO_ERR_FLAGS_EN
module async_fifo #(
  parameter int WIDTH   = 8,
  parameter int SIZE    = 8,
  parameter int PTR_LEN = $clog2(SIZE)
) (
  input  logic               wclk,
  input  logic               arst_n,
  input  logic               w_en,
  input  logic [WIDTH-1:0]   data_in,
  input  logic               r_en,
  output logic [WIDTH-1:0]   data_out,
  output logic               full,
  output logic               empty,
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  output logic               overflow,
  output logic               underflow,
`endif
  output logic [PTR_LEN:0]   count
);

  localparam logic [PTR_LEN:0] PTR_INC = {{PTR_LEN{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [SIZE];
  logic [PTR_LEN:0] wptr_q, wptr_d;
  logic [PTR_LEN:0] rptr_q, rptr_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic             wr_acc;
  logic             rd_acc;

  // Flags come straight from the registered pointers; the MSB is the wrap bit,
  // so equal low bits with differing wrap bits means SIZE words are stored.
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[PTR_LEN-1:0] == rptr_q[PTR_LEN-1:0]) &&
                 (wptr_q[PTR_LEN] != rptr_q[PTR_LEN]);
  assign count = wptr_q - rptr_q;

  // Acceptance uses the pre-edge flags, so at full a simultaneous read frees
  // no room for this cycle's write (and vice versa at empty).
  assign wr_acc = w_en && !full;
  assign rd_acc = r_en && !empty;

  assign data_out = data_out_q;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    data_out_d = data_out_q;
    if (wr_acc) begin
      wptr_d = wptr_q + PTR_INC;
    end
    if (rd_acc) begin
      rptr_d     = rptr_q + PTR_INC;
      data_out_d = mem_q[rptr_q[PTR_LEN-1:0]];
    end
  end

  always_ff @(posedge wclk or negedge arst_n) begin
    if (!arst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      data_out_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      data_out_q <= data_out_d;
    end
  end

  // Storage is deliberately left out of reset; the pointers alone define validity.
  always_ff @(posedge wclk) begin
    if (wr_acc) begin
      mem_q[wptr_q[PTR_LEN-1:0]] <= data_in;
    end
  end

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  // Sticky until reset: once set, only arst_n clears them.
  always_comb begin
    overflow_d  = overflow_q  || (w_en && full);
    underflow_d = underflow_q || (r_en && empty);
  end

  always_ff @(posedge wclk or negedge arst_n) begin
    if (!arst_n) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_async_fifo.sv
// Purpose : self-checking bench for async_fifo against a queue-based reference model.
// Latency : compares all outputs 1 time unit after every rising edge and right after reset assertion.
// Backpr. : model drops writes at SIZE entries and reads at 0 entries, using the pre-edge occupancy.
module tb_async_fifo;

  localparam int WIDTH   = 8;
  localparam int SIZE    = 8;
  localparam int PTR_LEN = $clog2(SIZE);

  logic               wclk;
  logic               arst_n;
  logic               w_en;
  logic [WIDTH-1:0]   data_in;
  logic               r_en;
  logic [WIDTH-1:0]   data_out;
  logic               full;
  logic               empty;
  logic [PTR_LEN:0]   count;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic               overflow;
  logic               underflow;
`endif

  async_fifo #(.WIDTH(WIDTH), .SIZE(SIZE), .PTR_LEN(PTR_LEN)) dut (
    .wclk     (wclk),
    .arst_n   (arst_n),
    .w_en     (w_en),
    .data_in  (data_in),
    .r_en     (r_en),
    .data_out (data_out),
    .full     (full),
    .empty    (empty),
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    .overflow (overflow),
    .underflow(underflow),
`endif
    .count    (count)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  int checks   = 0;
  int failures = 0;

  // Reference model: contents as a plain queue, plus the last value read out.
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] exp_dout;
  logic             exp_ovf;
  logic             exp_unf;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".count"}, 32'(count), 32'(model_q.size()));
    check({tag, ".full"},  32'(full),  32'(model_q.size() == SIZE));
    check({tag, ".empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({tag, ".dout"},  32'(data_out), 32'(exp_dout));
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    check({tag, ".ovf"}, 32'(overflow),  32'(exp_ovf));
    check({tag, ".unf"}, 32'(underflow), 32'(exp_unf));
`endif
  endtask

  // One clock: drive requests, let the edge happen, advance the model, compare.
  task automatic step(input logic w, input logic [WIDTH-1:0] d, input logic r, input string tag);
    bit wa, ra;
    w_en    = w;
    data_in = d;
    r_en    = r;
    @(posedge wclk);
    wa = w && (model_q.size() < SIZE);
    ra = r && (model_q.size() > 0);
    if (w && !wa) exp_ovf = 1'b1;
    if (r && !ra) exp_unf = 1'b1;
    if (ra) exp_dout = model_q.pop_front();
    if (wa) model_q.push_back(d);
    #1;
    w_en = 1'b0;
    r_en = 1'b0;
    check_all(tag);
  endtask

  // Pulse reset between edges and check outputs respond without a clock.
  task automatic pulse_reset(input string tag);
    #1;
    arst_n = 1'b0;
    #1;
    model_q.delete();
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
    check_all(tag);
    #1;
    arst_n = 1'b1;
  endtask

  initial begin
    w_en     = 1'b0;
    r_en     = 1'b0;
    data_in  = '0;
    arst_n   = 1'b0;
    exp_dout = '0;
    exp_ovf  = 1'b0;
    exp_unf  = 1'b0;
    #2;
    check_all("reset0");
    #5;
    arst_n = 1'b1;
    @(posedge wclk);
    #1;

    // Fill 0x11..0x88, then a dropped 9th write.
    for (int i = 1; i <= 8; i++) step(1'b1, WIDTH'(8'h11 * i), 1'b0, "fill");
    check("fill.full8", 32'(full), 32'd1);
    check("fill.cnt8", 32'(count), 32'd8);
    step(1'b1, 8'hEE, 1'b0, "fill9_drop");

    // Drain in order, then a dropped 9th read keeps 0x88.
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, '0, 1'b1, "drain");
      check("drain.val", 32'(data_out), 32'(8'h11 * i));
    end
    step(1'b0, '0, 1'b1, "drain9_drop");
    check("drain9.hold", 32'(data_out), 32'h88);

    // Wrap: write 4, read 2, write 3, read 5 (pointers already at 8 -> wrap bit set).
    for (int i = 0; i < 4; i++) step(1'b1, WIDTH'(8'hA0 + i), 1'b0, "wrap.w4");
    check("wrap.c4", 32'(count), 32'd4);
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, "wrap.r2");
    check("wrap.c2", 32'(count), 32'd2);
    for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(8'hB0 + i), 1'b0, "wrap.w3");
    check("wrap.c5", 32'(count), 32'd5);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1, "wrap.r5");
    check("wrap.c0", 32'(count), 32'd0);
    check("wrap.last", 32'(data_out), 32'hB2);

    // Simultaneous: at empty only the write lands; at 3 count holds; at full only the read.
    step(1'b1, 8'h5A, 1'b1, "sim.empty");
    check("sim.empty.c1", 32'(count), 32'd1);
    step(1'b1, 8'h5B, 1'b0, "sim.pre");
    step(1'b1, 8'h5C, 1'b0, "sim.pre");
    step(1'b1, 8'h5D, 1'b1, "sim.c3");
    check("sim.c3.hold", 32'(count), 32'd3);
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(8'h60 + i), 1'b0, "sim.fill");
    step(1'b1, 8'h77, 1'b1, "sim.full");
    check("sim.full.c7", 32'(count), 32'd7);

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    step(1'b1, 8'h01, 1'b0, "ef.fill");
    step(1'b1, 8'h02, 1'b0, "ef.ovf");
    check("ef.ovf_set", 32'(overflow), 32'd1);
    step(1'b0, '0, 1'b1, "ef.hold");
    check("ef.ovf_sticky", 32'(overflow), 32'd1);
`endif

    // Reset mid-operation discards contents.
    pulse_reset("reset_mid");
    step(1'b0, '0, 1'b1, "post_reset_rd");
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    check("ef.unf_set", 32'(underflow), 32'd1);
`endif
    step(1'b1, 8'h3C, 1'b0, "post_reset_wr");

    // Randomized phases biased toward writing or reading to reach both flags.
    for (int ph = 0; ph < 8; ph++) begin
      for (int n = 0; n < 60; n++) begin
        logic w, r;
        w = ($urandom_range(0, 9) < ((ph % 2 == 0) ? 7 : 3));
        r = ($urandom_range(0, 9) < ((ph % 2 == 0) ? 3 : 7));
        step(w, WIDTH'($urandom), r, "rand");
      end
    end
    pulse_reset("reset_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
